mem_access_unit: RTL and testbench

MEM-stage data-memory access controller for the 5-stage MIPS pipeline. It takes a load/store from the EX/MEM register and runs a req/ack transaction on the data-memory port. It formats store byte-lanes, sign- or zero-extends load data into the `rdata` value captured by the MEM/WB register, and raises address-error exceptions toward CP0. While a transaction is outstanding it stalls the whole pipeline.

---
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: runs one req/ack transaction per
// load/store, formats store lanes, extends load data, flags address errors.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        killed;
    logic        read_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic        is_store;
    logic        misaligned;
    logic        access;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Access decode, address-error detection and pipeline stall
    always_comb begin
        is_store   = mem_write & ~mem_read;
        misaligned = ((mem_size == 2'b01) & addr[0]) |
                     (mem_size[1] & (addr[1:0] != 2'b00));
        access     = in_valid & (mem_read | mem_write) & ~misaligned & ~flush;
        adel       = ~reset & (state == IDLE) & in_valid & mem_read & misaligned & ~flush;
        ades       = ~reset & (state == IDLE) & in_valid & is_store & misaligned & ~flush;
        badvaddr   = (adel | ades) ? addr : '0;
        stall_req  = ~reset & (((state == IDLE) & access) | (state == WAIT));
        done       = ~reset & (state == DONE);
    end

    // Store lane formatting; loads always fetch the full word
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata;
        if (is_store) begin
            case (mem_size)
                2'b00: begin
                    be_fmt    = 4'b0001 << addr[1:0];
                    wdata_fmt = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_fmt = {2{wdata[15:0]}};
                end
                default: begin
                    be_fmt    = 4'b1111;
                    wdata_fmt = wdata;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension from the latched size/offset
    always_comb begin
        shifted = dm_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = dm_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state; a flush coinciding with ack still kills the access
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access) state_next = WAIT;
            WAIT: if (dm_ack) state_next = (killed | flush) ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus request registers, transaction context and load result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= '0;
            dm_wdata <= '0;
            killed   <= 1'b0;
            read_q   <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_addr  <= {addr[31:2], 2'b00};
                        dm_be    <= be_fmt;
                        dm_wdata <= wdata_fmt;
                        killed   <= 1'b0;
                        read_q   <= mem_read;
                        uns_q    <= mem_unsigned;
                        size_q   <= mem_size;
                        off_q    <= addr[1:0];
                    end
                end
                WAIT: begin
                    if (flush) killed <= 1'b1;
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (~(killed | flush) & read_q) rdata <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: load results go through a
// scoreboard queue, bus fields and handshake timing are checked per access.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] rdata_ref = '0;
    logic [31:0] sb_q[$];

    mem_access_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr(addr), .wdata(wdata), .flush(flush), .stall_req(stall_req),
        .done(done), .rdata(rdata), .adel(adel), .ades(ades), .badvaddr(badvaddr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                             input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0: return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1: return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic st, input logic [1:0] sz, input logic [1:0] off);
        if (!st) return 4'hF;
        case (sz)
            2'd0: case (off)
                      2'd0: return 4'b0001;
                      2'd1: return 4'b0010;
                      2'd2: return 4'b0100;
                      default: return 4'b1000;
                  endcase
            2'd1: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'd0: return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'd1: return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    // Runs one aligned access; call at posedge+1. Ack lands in cycle 1+waits.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rw, input int waits, input int flush_cyc);
        int  ack_cyc;
        int  stall_cnt;
        int  done_cnt;
        int  done_cyc;
        bit  killed;
        logic st;
        ack_cyc   = 1 + waits;
        killed    = (flush_cyc >= 1) && (flush_cyc <= ack_cyc);
        st        = wr & ~rd;
        stall_cnt = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        addr = a; wdata = wd;
        if (rd && !killed) sb_q.push_back(exp_load(sz, uns, a[1:0], rw));
        for (int c = 0; c <= ack_cyc + 2; c++) begin
            in_valid = (c <= ack_cyc);
            dm_ack   = (c == ack_cyc);
            flush    = (c == flush_cyc);
            dm_rdata = (c == ack_cyc) ? rw : $urandom;
            @(negedge clk);
            if (stall_req) stall_cnt++;
            if (c == 1 || c == ack_cyc) begin
                check("dm_req", {31'b0, dm_req}, 32'd1);
                check("dm_we", {31'b0, dm_we}, {31'b0, st});
                check("dm_addr", dm_addr, {a[31:2], 2'b00});
                check("dm_be", {28'b0, dm_be}, {28'b0, exp_be(st, sz, a[1:0])});
                if (st) check("dm_wdata", dm_wdata, exp_wd(sz, wd));
            end
            if (c == ack_cyc + 1) check("dm_req_drop", {31'b0, dm_req}, 32'd0);
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (rd) begin
                    if (sb_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
                    else begin
                        rdata_ref = sb_q.pop_front();
                        check("rdata", rdata, rdata_ref);
                    end
                end else begin
                    check("rdata_store", rdata, rdata_ref);
                end
            end
            @(posedge clk);
            #1;
        end
        check("stall_cycles", stall_cnt, ack_cyc + 1);
        check("done_count", done_cnt, killed ? 0 : 1);
        check("done_cycle", done_cyc, killed ? -1 : ack_cyc + 1);
        if (killed) check("rdata_killed", rdata, rdata_ref);
    endtask

    task automatic misaligned(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [31:0] a);
        in_valid = 1; mem_read = rd; mem_write = wr; mem_size = sz; addr = a;
        mem_unsigned = 0; flush = 0; dm_ack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("adel", {31'b0, adel}, {31'b0, rd});
            check("ades", {31'b0, ades}, {31'b0, wr & ~rd});
            check("badvaddr", badvaddr, a);
            check("mis_stall", {31'b0, stall_req}, 32'd0);
            check("mis_req", {31'b0, dm_req}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic        rd;
        reset = 1; in_valid = 0; mem_read = 0; mem_write = 0; mem_size = 0;
        mem_unsigned = 0; addr = 0; wdata = 0; flush = 0; dm_ack = 0; dm_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_stall", {31'b0, stall_req}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_req", {31'b0, dm_req}, 32'd0);
        check("rst_addr", dm_addr, 32'd0);
        check("rst_be", {28'b0, dm_be}, 32'd0);
        check("rst_badv", badvaddr, 32'd0);
        @(posedge clk);
        #1;

        run_access(1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF_FF00, 0, -1);
        run_access(1, 0, 2'd1, 1, 32'h2002, 32'h0, 32'hBEEF_1234, 3, -1);
        run_access(0, 1, 2'd1, 0, 32'h10, 32'h1234_ABCD, 32'h0, 1, -1);
        misaligned(1, 0, 2'd2, 32'h1002);
        misaligned(0, 1, 2'd2, 32'h5);
        misaligned(1, 1, 2'd1, 32'h7);
        run_access(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hCAFE_F00D, 2, 1);
        run_access(1, 0, 2'd2, 0, 32'h104, 32'h0, 32'h1357_9BDF, 1, 2);
        run_access(1, 1, 2'd0, 0, 32'h201, 32'h0, 32'h0000_7F00, 0, -1);

        // Reset while waiting on the bus
        in_valid = 1; mem_read = 1; mem_write = 0; mem_size = 2'd2; addr = 32'h40;
        dm_ack = 0; flush = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_req", {31'b0, dm_req}, 32'd1);
        reset = 1; in_valid = 0;
        @(posedge clk);
        #1 reset = 0;
        rdata_ref = '0;
        @(negedge clk);
        check("wrst_req", {31'b0, dm_req}, 32'd0);
        check("wrst_stall", {31'b0, stall_req}, 32'd0);
        check("wrst_rdata", rdata, 32'd0);
        check("wrst_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        run_access(1, 0, 2'd0, 0, 32'h3002, 32'h0, 32'h0055_0000, 0, -1);

        for (int i = 0; i < 10; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            rd = 1'($urandom_range(0, 1));
            run_access(rd, ~rd, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                       $urandom_range(0, 3), -1);
        end

        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
